fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have the parameter PC_STEP, default 16'd1, giving the PC increment per fetched instruction.
REQ-003 The block SHALL have the parameter HALT_OPCODE, default 4'hF, giving the instruction[15:12] value that halts fetching.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input is allowed.
REQ-005 Ports SHALL be:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous active-high reset.
- MemAddr  output  16  PC presented to the combinational InstrMemory.
- MemInstr  input  16  instruction returned by InstrMemory for MemAddr, same cycle.
- Stall  input  1  suppresses new fetches while held.
- Redirect  input  1  branch/jump taken; flushes and reloads PC.
- RedirectPC  input  16  target PC, valid when Redirect=1.
- DecReady  input  1  decode accepts the head entry this cycle.
- FetchValid  output  1  head entry valid.
- FetchInstr  output  16  head entry instruction.
- FetchPC  output  16  head entry PC.
- Halted  output  1  halt opcode fetched; fetching stopped.

Function
REQ-006 The block SHALL hold a 16-bit PC register and drive MemAddr = PC combinationally.
REQ-007 The block SHALL hold a 2-entry FIFO of {PC, instruction}; FetchValid = (count != 0); FetchInstr and FetchPC come from the head entry and are 16'h0000 when count = 0.
REQ-008 A pop SHALL occur when FetchValid=1 and DecReady=1.
REQ-009 A fetch SHALL occur when state=RUN, Stall=0, Redirect=0, and (count<2 or a pop occurs this cycle); {PC, MemInstr} is enqueued at the clock edge.
REQ-010 On a fetch, PC SHALL become PC+PC_STEP modulo 2^16 (16'hFFFF+1 -> 16'h0000), unless the fetched instruction is a halt.
REQ-011 Latency SHALL be one cycle: an instruction fetched at edge N is visible on FetchValid/FetchInstr after edge N.
REQ-012 The FSM SHALL have states RUN and HALT; reset enters RUN.
REQ-013 RUN->HALT SHALL occur when a fetch enqueues MemInstr[15:12]=HALT_OPCODE; that entry is still enqueued, PC stays at the halt address, and Halted=1 from the next cycle.
REQ-014 In HALT the block SHALL do no fetches; it SHALL continue popping for DecReady until the FIFO drains.
REQ-015 Redirect=1 SHALL have priority over fetch, pop and Stall: count->0, PC->RedirectPC, state->RUN, Halted->0, no fetch or enqueue that cycle.
REQ-016 Simultaneous pop and fetch at count=2 SHALL leave count=2 and preserve order; at count=1 SHALL leave count=1.
REQ-017 The count SHALL never exceed 2 or underflow; no pop at count=0.

Reset
REQ-018 With Reset=1 at an edge, the block SHALL set PC=RESET_PC, count=0, state=RUN, FetchValid=0, Halted=0, and FetchInstr=FetchPC=16'h0000.
REQ-019 Reset SHALL override all other inputs, including Redirect, in the same cycle, and SHALL abort any in-progress operation.

Verification
REQ-020 The bench SHALL cover: reset, then DecReady=1, memory returning 16'h1000+addr -> FetchPC 0,1,2,... and FetchInstr 16'h1000,16'h1001,... one per cycle, first valid one cycle after reset release.
REQ-021 The bench SHALL cover: DecReady=0 for 5 cycles -> after 2 fetches count=2, PC=2, MemAddr holds 2, head is PC=0; release -> PC 0,1,2 delivered in order with no loss or duplication.
REQ-022 The bench SHALL cover: Redirect=1 with RedirectPC=16'h000A while count=2 -> next cycle FetchValid=0 and MemAddr=16'h000A; the following cycle FetchPC=16'h000A.
REQ-023 The bench SHALL cover: memory at addr 3 = 16'hF000 -> entry PC=3 delivered, Halted=1, MemAddr stays 3, and no further entries; then Redirect to 16'h0000 -> Halted=0 and fetching resumes.
REQ-024 The bench SHALL cover: RedirectPC=16'hFFFF -> FetchPC 16'hFFFF then 16'h0000 (wrap).
REQ-025 The bench SHALL cover: Reset=1 asserted together with Redirect=1 mid-stream -> next cycle PC=RESET_PC, FetchValid=0, Halted=0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register plus a 2-entry {PC, instr} queue feeding decode.
// One-cycle fetch-to-visible latency; fetch stalls when the queue is full and decode does not pop.
module fetch_controller #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] PC_STEP     = 16'd1,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [15:0] MemAddr,
   input  logic [15:0] MemInstr,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [15:0] RedirectPC,
   input  logic        DecReady,
   output logic        FetchValid,
   output logic [15:0] FetchInstr,
   output logic [15:0] FetchPC,
   output logic        Halted
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
   logic [15:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;
   logic        pop, fetch, is_halt;
   logic [1:0]  slot;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         count_q    <= 2'd0;
         e0_pc_q    <= 16'h0000;
         e0_instr_q <= 16'h0000;
         e1_pc_q    <= 16'h0000;
         e1_instr_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         e0_pc_q    <= e0_pc_d;
         e0_instr_q <= e0_instr_d;
         e1_pc_q    <= e1_pc_d;
         e1_instr_q <= e1_instr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      e0_pc_d    = e0_pc_q;
      e0_instr_d = e0_instr_q;
      e1_pc_d    = e1_pc_q;
      e1_instr_d = e1_instr_q;
      pop        = (count_q != 2'd0) && DecReady;
      fetch      = (state_q == RUN) && !Stall && !Redirect && ((count_q < 2'd2) || pop);
      is_halt    = (MemInstr[15:12] == HALT_OPCODE);
      slot       = count_q - {1'b0, pop};

      if (Redirect) begin
         // Flush wins over everything else in the cycle.
         count_d = 2'd0;
         pc_d    = RedirectPC;
         state_d = RUN;
      end else begin
         if (pop) begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
         end
         if (fetch) begin
            // Slot is where the new entry lands after this cycle's pop shifts the queue.
            if (slot == 2'd0) begin
               e0_pc_d    = pc_q;
               e0_instr_d = MemInstr;
            end else begin
               e1_pc_d    = pc_q;
               e1_instr_d = MemInstr;
            end
            if (is_halt) begin
               state_d = HALT;
            end else begin
               pc_d = pc_q + PC_STEP;
            end
         end
         count_d = count_q + {1'b0, fetch} - {1'b0, pop};
      end
   end

   assign MemAddr    = pc_q;
   assign FetchValid = (count_q != 2'd0);
   assign FetchInstr = FetchValid ? e0_instr_q : 16'h0000;
   assign FetchPC    = FetchValid ? e0_pc_q : 16'h0000;
   assign Halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus hand-written halt/reset sequence.
module tb_fetch_controller;

   logic        Clock = 1'b0;
   logic        Reset, Stall, Redirect, DecReady;
   logic [15:0] RedirectPC, MemAddr, MemInstr, FetchInstr, FetchPC;
   logic        FetchValid, Halted;
   logic        halt_en;
   logic [15:0] mem_sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   // Memory returns 16'h1000+addr, or a halt opcode at address 3 when enabled.
   assign mem_sum  = MemAddr + 16'h1000;
   assign MemInstr = (halt_en && MemAddr == 16'h0003) ? 16'hF000 : mem_sum;

   fetch_controller dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .MemAddr    (MemAddr),
      .MemInstr   (MemInstr),
      .Stall      (Stall),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .DecReady   (DecReady),
      .FetchValid (FetchValid),
      .FetchInstr (FetchInstr),
      .FetchPC    (FetchPC),
      .Halted     (Halted)
   );

   typedef struct {
      logic        rst, stall, redir;
      logic [15:0] rpc;
      logic        drdy, hen;
      logic        valid;
      logic [15:0] instr, fpc;
      logic        halted;
      logic [15:0] addr;
   } vec_t;

   vec_t vt[31];

   function automatic vec_t mk(input logic rst, stall, redir, input logic [15:0] rpc,
                               input logic drdy, hen, valid, input logic [15:0] instr, fpc,
                               input logic halted, input logic [15:0] addr);
      vec_t v;
      v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.drdy = drdy; v.hen = hen;
      v.valid = valid; v.instr = instr; v.fpc = fpc; v.halted = halted; v.addr = addr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic rst, stall, redir, input logic [15:0] rpc, input logic drdy, hen);
      @(negedge Clock);
      Reset = rst; Stall = stall; Redirect = redir; RedirectPC = rpc; DecReady = drdy; halt_en = hen;
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic valid, input logic [15:0] instr, fpc,
                          input logic halted, input logic [15:0] addr);
      chk({tag, ".valid"},  {15'd0, FetchValid}, {15'd0, valid});
      chk({tag, ".instr"},  FetchInstr, instr);
      chk({tag, ".pc"},     FetchPC, fpc);
      chk({tag, ".halted"}, {15'd0, Halted}, {15'd0, halted});
      chk({tag, ".addr"},   MemAddr, addr);
   endtask

   initial begin
      Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
      DecReady = 1'b0; halt_en = 1'b0;

      //          rst stl rdr rpc       rdy hen  vld instr     fpc       hlt addr
      // streaming after reset, one instruction per cycle
      vt[0]  = mk(1, 0, 0, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      vt[1]  = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1000, 16'h0000, 0, 16'h0001);
      vt[2]  = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1001, 16'h0001, 0, 16'h0002);
      vt[3]  = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1002, 16'h0002, 0, 16'h0003);
      // decode backpressure: queue fills to 2, then drains in order
      vt[4]  = mk(1, 0, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      vt[5]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0001);
      vt[6]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0002);
      vt[7]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0002);
      vt[8]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0002);
      vt[9]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0002);
      vt[10] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1001, 16'h0001, 0, 16'h0003);
      vt[11] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1002, 16'h0002, 0, 16'h0004);
      // redirect with a full queue
      vt[12] = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1002, 16'h0002, 0, 16'h0004);
      vt[13] = mk(0, 0, 1, 16'h000A, 0, 0,  0, 16'h0000, 16'h0000, 0, 16'h000A);
      vt[14] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h100A, 16'h000A, 0, 16'h000B);
      // halt opcode at address 3, then redirect out of HALT
      vt[15] = mk(0, 0, 1, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      vt[16] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 16'h1000, 16'h0000, 0, 16'h0001);
      vt[17] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 16'h1001, 16'h0001, 0, 16'h0002);
      vt[18] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 16'h1002, 16'h0002, 0, 16'h0003);
      vt[19] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 16'hF000, 16'h0003, 1, 16'h0003);
      vt[20] = mk(0, 0, 0, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 1, 16'h0003);
      vt[21] = mk(0, 0, 0, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 1, 16'h0003);
      vt[22] = mk(0, 0, 1, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      vt[23] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 16'h1000, 16'h0000, 0, 16'h0001);
      // PC wrap at 16'hFFFF
      vt[24] = mk(0, 0, 1, 16'hFFFF, 1, 0,  0, 16'h0000, 16'h0000, 0, 16'hFFFF);
      vt[25] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h0FFF, 16'hFFFF, 0, 16'h0000);
      vt[26] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1000, 16'h0000, 0, 16'h0001);
      // reset together with redirect while queue holds 2 entries
      vt[27] = mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h1000, 16'h0000, 0, 16'h0002);
      vt[28] = mk(1, 0, 1, 16'h0055, 1, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      // stall suppresses fetch
      vt[29] = mk(0, 1, 0, 16'h0000, 1, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
      vt[30] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 16'h1000, 16'h0000, 0, 16'h0001);

      for (int i = 0; i < 31; i++) begin
         step(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].rpc, vt[i].drdy, vt[i].hen);
         chk_all($sformatf("v%0d", i), vt[i].valid, vt[i].instr, vt[i].fpc, vt[i].halted, vt[i].addr);
      end

      // Halt while decode is blocked: entry stays queued, then reset+redirect clears HALT.
      step(0, 0, 1, 16'h0003, 0, 1);
      chk_all("h0", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0003);
      step(0, 0, 0, 16'h0000, 0, 1);
      chk_all("h1", 1'b1, 16'hF000, 16'h0003, 1'b1, 16'h0003);
      step(0, 0, 0, 16'h0000, 0, 1);
      chk_all("h2", 1'b1, 16'hF000, 16'h0003, 1'b1, 16'h0003);
      step(1, 0, 1, 16'h0007, 1, 1);
      chk_all("h3", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      step(0, 0, 0, 16'h0000, 1, 0);
      chk_all("h4", 1'b1, 16'h1000, 16'h0000, 1'b0, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
